// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART frame receiver:
//     rx_state_e    receiver FSM states
//     OVERSAMPLE    oversample ticks per bit period
//     TICK_S0..S2   tick indexes at which a bit is sampled (majority vote)
//     TICK_END      last tick index of a bit period
//     majority3()   2-of-3 vote used to resolve each bit
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } rx_state_e;

    localparam int OVERSAMPLE = 8;

    localparam logic [2:0] TICK_S0  = 3'd3;
    localparam logic [2:0] TICK_S1  = 3'd4;
    localparam logic [2:0] TICK_S2  = 3'd5;
    localparam logic [2:0] TICK_END = 3'd7;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Oversample tick generator: one-cycle tick every max(prescale,1) clocks.
//   Ports:
//     clk       clock (rising edge)
//     rst_n     asynchronous active-low reset
//     clear     holds the counter at zero and suppresses ticks
//     prescale  clocks per tick (0 is treated as 1)
//     tick      one-cycle oversample tick
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] period_m1;

    always_comb begin
        period_m1 = (prescale == 16'd0) ? 16'd0 : (prescale - 16'd1);
        // ">=" rather than "==" keeps the counter from running away if the
        // counter value ever exceeds the terminal count.
        tick      = !clear && (cnt_q >= period_m1);
        if (clear || tick) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   UART receiver with 8x oversampling, majority-vote bit sampling, optional
//   parity, break detection and an AXI-Stream style output register.
//   Ports:
//     clk, rst_n        clock / asynchronous active-low reset
//     rxd               serial line, idle high, LSB first
//     prescale          clocks per oversample tick (bit = prescale*8 clocks)
//     m_axis_tdata      received data word
//     m_axis_tvalid     data valid, held until accepted
//     m_axis_tready     downstream accept
//     busy              receiver FSM not idle
//     overrun_error     pulse: good frame overwrote unaccepted data
//     frame_error       pulse: stop bit sampled low
//     parity_error      pulse: parity mismatch, frame dropped
//     break_detect      pulse: all-zero frame with low stop bit
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  break_detect
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic       ODD_BIT  = (PARITY_ODD != 0);
    localparam bit         HAS_PAR  = (PARITY_EN != 0);

    // Synchronizer plus one extra flop for falling-edge detection.
    logic rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic rxd_sync;
    logic rxd_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    assign rxd_sync = rxd_s2_q;
    assign rxd_fall = rxd_prev_q & ~rxd_sync;

    rx_state_e             state_q, state_d;
    logic [15:0]           prescale_q;
    logic [2:0]            idx_q, idx_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  ovr_q, ovr_d;
    logic                  fe_q, fe_d;
    logic                  pe_q, pe_d;
    logic                  brk_q, brk_d;
    logic                  baud_clear;
    logic                  tick;
    logic                  bit_val;

    // The bit period is frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= 16'd0;
        end else if (state_q == ST_IDLE) begin
            prescale_q <= prescale;
        end
    end

    uart_baud_tick u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .prescale (prescale_q),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q & ~m_axis_tready;
        ovr_d      = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
        brk_d      = 1'b0;
        baud_clear = 1'b0;
        // Third vote comes straight from the line at the last sample tick.
        bit_val    = majority3(samp_q[0], samp_q[1], rxd_sync);

        if (tick && (state_q != ST_IDLE) && (state_q != ST_BRK)) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == TICK_S0) samp_d[0] = rxd_sync;
            if (idx_q == TICK_S1) samp_d[1] = rxd_sync;
        end

        case (state_q)
            ST_IDLE: begin
                baud_clear = 1'b1;
                idx_d      = 3'd0;
                bit_cnt_d  = 4'd0;
                par_bit_d  = 1'b0;
                par_err_d  = 1'b0;
                if (rxd_fall) state_d = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (idx_q == TICK_S2 && bit_val) state_d = ST_IDLE;
                    else if (idx_q == TICK_END)      state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == TICK_S2) begin
                        shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    end else if (idx_q == TICK_END) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (idx_q == TICK_S2) begin
                        par_bit_d = bit_val;
                        par_err_d = bit_val != ((^shift_q) ^ ODD_BIT);
                    end else if (idx_q == TICK_END) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Resolve at the middle of the stop bit so a start edge that
                // follows immediately is still seen from IDLE.
                if (tick && idx_q == TICK_S2) begin
                    state_d = ST_IDLE;
                    if (bit_val) begin
                        if (par_err_q) begin
                            pe_d = 1'b1;
                        end else begin
                            tdata_d  = shift_q;
                            tvalid_d = 1'b1;
                            ovr_d    = tvalid_q & ~m_axis_tready;
                        end
                    end else begin
                        fe_d = 1'b1;
                        if (shift_q == '0 && !par_bit_q) begin
                            brk_d   = 1'b1;
                            state_d = ST_BRK;
                        end
                    end
                end
            end
            ST_BRK: begin
                baud_clear = 1'b1;
                if (rxd_sync) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            samp_q    <= 2'b00;
            shift_q   <= '0;
            bit_cnt_q <= 4'd0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            brk_q     <= brk_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun_error = ovr_q;
    assign frame_error   = fe_q;
    assign parity_error  = pe_q;
    assign break_detect  = brk_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
//   Directed bench: dut_a is 8N1, dut_b is 8E1. Shared clock, reset and
//   prescale; each DUT has its own line and ready.
module tb_uart_frame_rx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] prescale;
    logic        rxd_a, rxd_b;
    logic        tready_a, tready_b;
    logic [7:0]  tdata_a, tdata_b;
    logic        tvalid_a, tvalid_b;
    logic        busy_a, busy_b;
    logic        ovr_a, fe_a, pe_a, brk_a;
    logic        ovr_b, fe_b, pe_b, brk_b;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters, written only by the monitor below.
    int a_fe = 0, a_brk = 0, a_pe = 0, a_ovr = 0, a_same = 0, a_vcyc = 0, a_acc = 0;
    int b_fe = 0, b_brk = 0, b_pe = 0, b_ovr = 0, b_vcyc = 0, b_acc = 0;
    logic [7:0] a_last = 8'h00, b_last = 8'h00;

    always #5 clk = ~clk;

    uart_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .prescale(prescale),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .busy(busy_a), .overrun_error(ovr_a), .frame_error(fe_a),
        .parity_error(pe_a), .break_detect(brk_a)
    );

    uart_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .prescale(prescale),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .busy(busy_b), .overrun_error(ovr_b), .frame_error(fe_b),
        .parity_error(pe_b), .break_detect(brk_b)
    );

    always @(negedge clk) begin
        if (fe_a)          a_fe   <= a_fe + 1;
        if (brk_a)         a_brk  <= a_brk + 1;
        if (pe_a)          a_pe   <= a_pe + 1;
        if (ovr_a)         a_ovr  <= a_ovr + 1;
        if (fe_a && brk_a) a_same <= a_same + 1;
        if (tvalid_a)      a_vcyc <= a_vcyc + 1;
        if (tvalid_a && tready_a) begin
            a_acc  <= a_acc + 1;
            a_last <= tdata_a;
        end
        if (fe_b)     b_fe   <= b_fe + 1;
        if (brk_b)    b_brk  <= b_brk + 1;
        if (pe_b)     b_pe   <= b_pe + 1;
        if (ovr_b)    b_ovr  <= b_ovr + 1;
        if (tvalid_b) b_vcyc <= b_vcyc + 1;
        if (tvalid_b && tready_b) begin
            b_acc  <= b_acc + 1;
            b_last <= tdata_b;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd_a = v;
        else          rxd_b = v;
    endtask

    // Start, data LSB first, optional parity, stop; line left high afterwards.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par, input logic stop);
        int bp;
        bp = int'(prescale) * OVERSAMPLE;
        wait_clks(1);
        $display("tx dut=%0d data=0x%0h par=%0d/%0b stop=%0b prescale=%0d",
                 sel, data, has_par, par, stop, prescale);
        drive(sel, 1'b0);
        wait_clks(bp);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]);
            wait_clks(bp);
        end
        if (has_par) begin
            drive(sel, par);
            wait_clks(bp);
        end
        drive(sel, stop);
        wait_clks(bp);
        drive(sel, 1'b1);
    endtask

    task automatic test_reset;
        wait_clks(3);
        n_checks++;
        if ({tvalid_a, busy_a, ovr_a, fe_a, pe_a, brk_a} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs_a: got %b, expected 000000",
                     {tvalid_a, busy_a, ovr_a, fe_a, pe_a, brk_a});
        end
        n_checks++;
        if (tdata_a !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_tdata_a: got %0h, expected 00", tdata_a);
        end
        n_checks++;
        if ({tvalid_b, busy_b, ovr_b, fe_b, pe_b, brk_b} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs_b: got %b, expected 000000",
                     {tvalid_b, busy_b, ovr_b, fe_b, pe_b, brk_b});
        end
        rst_n = 1'b1;
        wait_clks(4);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy got %b, expected 0", busy_a);
        end
    endtask

    task automatic test_good_frame;
        int acc0, v0, st0;
        prescale = 16'd1;
        tready_a = 1'b1;
        acc0 = a_acc; v0 = a_vcyc; st0 = a_fe + a_pe + a_brk + a_ovr;
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
        wait_clks(16);
        n_checks++;
        if (a_acc - acc0 != 1 || a_last !== 8'hA5) begin
            n_errors++;
            $display("FAIL good_frame_data: got %0d beats data %0h, expected 1 beat data a5",
                     a_acc - acc0, a_last);
        end
        n_checks++;
        if (a_vcyc - v0 != 1) begin
            n_errors++;
            $display("FAIL good_frame_valid_len: got %0d cycles, expected 1", a_vcyc - v0);
        end
        n_checks++;
        if ((a_fe + a_pe + a_brk + a_ovr) - st0 != 0) begin
            n_errors++;
            $display("FAIL good_frame_status: got %0d pulses, expected 0",
                     (a_fe + a_pe + a_brk + a_ovr) - st0);
        end
    endtask

    task automatic test_false_start;
        int v0, st0;
        prescale = 16'd4;
        v0 = a_vcyc; st0 = a_fe + a_pe + a_brk + a_ovr;
        $display("tx dut=0 glitch low 2 clocks prescale=4");
        drive(0, 1'b0);
        wait_clks(2);
        drive(0, 1'b1);
        wait_clks(4);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_errors++;
            $display("FAIL false_start_busy: got %b, expected 1", busy_a);
        end
        wait_clks(100);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_errors++;
            $display("FAIL false_start_idle: busy got %b, expected 0", busy_a);
        end
        n_checks++;
        if (a_vcyc - v0 != 0 || (a_fe + a_pe + a_brk + a_ovr) - st0 != 0) begin
            n_errors++;
            $display("FAIL false_start_quiet: got %0d valid cycles %0d pulses, expected 0 0",
                     a_vcyc - v0, (a_fe + a_pe + a_brk + a_ovr) - st0);
        end
    endtask

    task automatic test_overrun;
        int ovr0, acc0;
        prescale = 16'd1;
        tready_a = 1'b0;
        ovr0 = a_ovr; acc0 = a_acc;
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
        wait_clks(16);
        n_checks++;
        if (a_ovr - ovr0 != 1) begin
            n_errors++;
            $display("FAIL overrun_count: got %0d, expected 1", a_ovr - ovr0);
        end
        n_checks++;
        if (tdata_a !== 8'h22 || tvalid_a !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_hold: got data %0h valid %b, expected 22 1", tdata_a, tvalid_a);
        end
        tready_a = 1'b1;
        wait_clks(3);
        n_checks++;
        if (a_acc - acc0 != 1 || a_last !== 8'h22 || tvalid_a !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_drain: got %0d beats data %0h valid %b, expected 1 22 0",
                     a_acc - acc0, a_last, tvalid_a);
        end
    endtask

    task automatic test_frame_error;
        int fe0, brk0, v0;
        prescale = 16'd1;
        fe0 = a_fe; brk0 = a_brk; v0 = a_vcyc;
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
        wait_clks(16);
        n_checks++;
        if (a_fe - fe0 != 1 || a_brk - brk0 != 0) begin
            n_errors++;
            $display("FAIL frame_error_pulses: got fe %0d brk %0d, expected 1 0",
                     a_fe - fe0, a_brk - brk0);
        end
        n_checks++;
        if (a_vcyc - v0 != 0) begin
            n_errors++;
            $display("FAIL frame_error_novalid: got %0d valid cycles, expected 0", a_vcyc - v0);
        end
    endtask

    task automatic test_break;
        int fe0, brk0, same0, acc0;
        prescale = 16'd1;
        fe0 = a_fe; brk0 = a_brk; same0 = a_same; acc0 = a_acc;
        wait_clks(1);
        $display("tx dut=0 break low for 20 bit periods");
        drive(0, 1'b0);
        wait_clks(20 * OVERSAMPLE);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_errors++;
            $display("FAIL break_busy: got %b, expected 1", busy_a);
        end
        n_checks++;
        if (a_fe - fe0 != 1 || a_brk - brk0 != 1 || a_same - same0 != 1) begin
            n_errors++;
            $display("FAIL break_pulses: got fe %0d brk %0d same %0d, expected 1 1 1",
                     a_fe - fe0, a_brk - brk0, a_same - same0);
        end
        drive(0, 1'b1);
        wait_clks(6);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_errors++;
            $display("FAIL break_release: busy got %b, expected 0", busy_a);
        end
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
        wait_clks(16);
        n_checks++;
        if (a_acc - acc0 != 1 || a_last !== 8'h5A) begin
            n_errors++;
            $display("FAIL after_break_frame: got %0d beats data %0h, expected 1 5a",
                     a_acc - acc0, a_last);
        end
    endtask

    task automatic test_parity;
        int pe0, v0, acc0;
        prescale = 16'd1;
        tready_b = 1'b1;
        pe0 = b_pe; v0 = b_vcyc;
        // 0x07 has three ones: even parity bit should be 1, send 0.
        send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b1);
        wait_clks(16);
        n_checks++;
        if (b_pe - pe0 != 1 || b_vcyc - v0 != 0) begin
            n_errors++;
            $display("FAIL parity_bad: got pe %0d valid cycles %0d, expected 1 0",
                     b_pe - pe0, b_vcyc - v0);
        end
        acc0 = b_acc; pe0 = b_pe;
        send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1'b1);
        wait_clks(16);
        n_checks++;
        if (b_acc - acc0 != 1 || b_last !== 8'h07 || b_pe - pe0 != 0) begin
            n_errors++;
            $display("FAIL parity_good: got %0d beats data %0h pe %0d, expected 1 07 0",
                     b_acc - acc0, b_last, b_pe - pe0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int acc0, st0;
        prescale = 16'd1;
        wait_clks(1);
        $display("tx dut=1 partial frame then reset");
        drive(1, 1'b0);
        wait_clks(OVERSAMPLE);
        drive(1, 1'b1);
        wait_clks(2 * OVERSAMPLE);
        n_checks++;
        if (busy_b !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_frame_busy: got %b, expected 1", busy_b);
        end
        rst_n = 1'b0;
        wait_clks(1);
        n_checks++;
        if (busy_b !== 1'b0 || tvalid_b !== 1'b0 || tdata_b !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_frame_reset: got busy %b valid %b data %0h, expected 0 0 00",
                     busy_b, tvalid_b, tdata_b);
        end
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(40);
        n_checks++;
        if (busy_b !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_needs_edge: busy got %b, expected 0", busy_b);
        end
        acc0 = b_acc; st0 = b_fe + b_pe + b_brk + b_ovr;
        // 0x81 has two ones: even parity bit 0.
        send_frame(1, 9'h081, 8, 1'b1, 1'b0, 1'b1);
        wait_clks(16);
        n_checks++;
        if (b_acc - acc0 != 1 || b_last !== 8'h81 || (b_fe + b_pe + b_brk + b_ovr) - st0 != 0) begin
            n_errors++;
            $display("FAIL after_reset_frame: got %0d beats data %0h pulses %0d, expected 1 81 0",
                     b_acc - acc0, b_last, (b_fe + b_pe + b_brk + b_ovr) - st0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rxd_a    = 1'b1;
        rxd_b    = 1'b1;
        tready_a = 1'b1;
        tready_b = 1'b1;
        prescale = 16'd1;
        test_reset();
        test_good_frame();
        test_false_start();
        test_overrun();
        test_frame_error();
        test_break();
        test_parity();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
